// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register-access responder
package spi_reg_pkg;

  localparam int SPI_ADDR_W       = 8;
  localparam int SPI_DATA_W       = 16;
  localparam int SPI_DUMMY_CYCLES = 8;
  localparam int SPI_SYNC_STAGES  = 2;

  localparam int READ_FLAG_BIT = SPI_ADDR_W - 1;

  // Writing this register address clears the sticky frame error.
  localparam logic [6:0] ERR_CLR_ADDR = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// rtl/spi_reg_slave_if.sv - SPI pad and register-bus signal bundle
interface spi_reg_slave_if #(
  parameter int ADDR_W = spi_reg_pkg::SPI_ADDR_W,
  parameter int DATA_W = spi_reg_pkg::SPI_DATA_W
);

  logic              spi_clk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-2:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;
  logic              frame_err;

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, bus_rdata, bus_rvalid,
    output spi_miso, bus_addr, bus_wdata, bus_we, bus_re, frame_err
  );

  modport master (
    output spi_clk, spi_cs_n, spi_mosi, bus_rdata, bus_rvalid,
    input  spi_miso, bus_addr, bus_wdata, bus_we, bus_re, frame_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with single-cycle rise/fall pulses
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI register-access responder bridging SCK frames onto the register bus
// Optional address echo on spi_miso during the address phase: define SPI_REG_ADDR_ECHO_EN.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W       = SPI_ADDR_W,
  parameter int DATA_W       = SPI_DATA_W,
  parameter int DUMMY_CYCLES = SPI_DUMMY_CYCLES,
  parameter int SYNC_STAGES  = SPI_SYNC_STAGES
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  spi_reg_slave_if.slave bus
);

  localparam int CNT_W = $clog2(max3(ADDR_W, DUMMY_CYCLES, DATA_W) + 1);

  logic                   sck_rise;
  logic                   sck_fall_unused;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_n_s;
  logic                   mosi_s;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic              is_read_q;
  logic              rvalid_seen_q;
  logic              we_pend_q;
  logic              miso_q;
  logic [ADDR_W-2:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_we_q;
  logic              bus_re_q;
  logic              frame_err_q;
`ifdef SPI_REG_ADDR_ECHO_EN
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] echo_sr_q;
`endif

  logic [ADDR_W-1:0] addr_shift_d;
  logic [DATA_W-1:0] rx_shift_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .d_i    (bus.spi_clk),
    .rise_o (sck_rise),
    .fall_o (sck_fall_unused)
  );

  // cs_n resets high so a held-low pad cannot start a frame mid-reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    end
  end

  assign cs_n_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
  assign addr_shift_d = {addr_sr_q[ADDR_W-2:0], mosi_s};
  assign rx_shift_d   = {rx_sr_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_sr_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      is_read_q     <= 1'b0;
      rvalid_seen_q <= 1'b0;
      we_pend_q     <= 1'b0;
      miso_q        <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_we_q      <= 1'b0;
      bus_re_q      <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef SPI_REG_ADDR_ECHO_EN
      last_addr_q   <= '0;
      echo_sr_q     <= '0;
`endif
    end else begin
      bus_re_q  <= 1'b0;
      bus_we_q  <= we_pend_q;
      we_pend_q <= 1'b0;
      if (we_pend_q && (bus_addr_q == (ADDR_W-1)'(ERR_CLR_ADDR))) begin
        frame_err_q <= 1'b0;
      end

      if (cs_n_s) begin
        // Deselect mid-frame aborts it; an issued bus_re is not recalled.
        if (state_q inside {ST_ADDR, ST_DUMMY, ST_DATA}) begin
          frame_err_q <= 1'b1;
        end
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q       <= ST_ADDR;
            cnt_q         <= '0;
            tx_sr_q       <= '0;
            is_read_q     <= 1'b0;
            rvalid_seen_q <= 1'b0;
`ifdef SPI_REG_ADDR_ECHO_EN
            echo_sr_q     <= last_addr_q;
`endif
          end

          ST_ADDR: begin
            if (sck_rise) begin
              addr_sr_q <= addr_shift_d;
              cnt_q     <= cnt_q + 1'b1;
`ifdef SPI_REG_ADDR_ECHO_EN
              miso_q    <= echo_sr_q[ADDR_W-1];
              echo_sr_q <= {echo_sr_q[ADDR_W-2:0], 1'b0};
`else
              miso_q    <= 1'b0;
`endif
              if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                bus_addr_q <= addr_shift_d[ADDR_W-2:0];
                is_read_q  <= addr_shift_d[ADDR_W-1];
                bus_re_q   <= addr_shift_d[ADDR_W-1];
                cnt_q      <= '0;
                state_q    <= ST_DUMMY;
              end
            end
          end

          ST_DUMMY: begin
            if (bus.bus_rvalid && is_read_q && !rvalid_seen_q) begin
              tx_sr_q       <= bus.bus_rdata;
              rvalid_seen_q <= 1'b1;
            end
            if (sck_rise) begin
              miso_q <= 1'b0;
              cnt_q  <= cnt_q + 1'b1;
              if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                cnt_q   <= '0;
                state_q <= ST_DATA;
                // Read latency budget exhausted: answer zeros and flag it.
                if (is_read_q && !rvalid_seen_q && !bus.bus_rvalid) begin
                  tx_sr_q     <= '0;
                  frame_err_q <= 1'b1;
                end
              end
            end
          end

          ST_DATA: begin
            if (sck_rise) begin
              rx_sr_q <= rx_shift_d;
              miso_q  <= tx_sr_q[DATA_W-1];
              tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                cnt_q   <= '0;
                state_q <= ST_DONE;
`ifdef SPI_REG_ADDR_ECHO_EN
                last_addr_q <= addr_sr_q;
`endif
                if (!is_read_q) begin
                  bus_wdata_q <= rx_shift_d;
                  we_pend_q   <= 1'b1;
                end
              end
            end
          end

          ST_DONE: begin
            state_q <= ST_DONE;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_re    = bus_re_q;
  assign bus.frame_err = frame_err_q;

endmodule
